// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle multiply/divide unit for the EX stage.
//   Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) on W-bit operands
//   and returns the HI/LO pair. While busy it raises stallreq so EX holds the op.
//   Optional macro MULDIV_FAST_MUL_EN: multiplies complete combinationally in
//   one cycle (IDLE -> DONE); divide is unchanged.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, op            request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b         rs / rt operands, sampled on the accepting edge only
//   annul                abort in-flight op; blocks acceptance in IDLE
//   stallreq             stall IF..EX
//   valid                one-cycle pulse, result_hi/result_lo hold a new result
//   result_hi/result_lo  product high/low or remainder/quotient
//   div_by_zero          divisor was zero (qualified by valid)
module ex_muldiv_unit #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         annul,
    output logic         stallreq,
    output logic         valid,
    output logic [W-1:0] result_hi,
    output logic [W-1:0] result_lo,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [W-1:0]       acc_q, acc_d;     // product high half or partial remainder
    logic [W-1:0]       lo_q, lo_d;       // multiplier / dividend, shifted out as result grows
    logic               neg_q, neg_d;     // product or quotient negative
    logic               rneg_q, rneg_d;   // remainder negative
    logic [W-1:0]       res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic               dbz_q, dbz_d;

    logic               signed_op, is_div;
    logic [W-1:0]       a_mag, b_mag;

    assign signed_op = ~op[0];
    assign is_div    = op[1];
    assign a_mag     = (signed_op && src_a[W-1]) ? -src_a : src_a;
    assign b_mag     = (signed_op && src_b[W-1]) ? -src_b : src_b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    // Extending to 2W bits makes the truncated product correct for both signednesses.
    assign fast_a    = {{W{signed_op & src_a[W-1]}}, src_a};
    assign fast_b    = {{W{signed_op & src_b[W-1]}}, src_b};
    assign fast_prod = fast_a * fast_b;
`else
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_acc_nx, mul_lo_nx;
    logic [2*W-1:0] prod_mag, prod_fin;
    assign mul_sum    = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign mul_acc_nx = mul_sum[W:1];
    assign mul_lo_nx  = {mul_sum[0], lo_q[W-1:1]};
    assign prod_mag   = {mul_acc_nx, mul_lo_nx};
    assign prod_fin   = neg_q ? -prod_mag : prod_mag;
`endif

    // Restoring step: the shifted remainder is W+1 bits; bit W of the
    // difference is the borrow, so a clear bit means the trial subtract fits.
    logic [W:0]   div_shift, div_diff;
    logic         div_ge;
    logic [W-1:0] div_acc_nx, div_lo_nx, quo_fin, rem_fin;
    assign div_shift  = {acc_q, lo_q[W-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign div_ge     = ~div_diff[W];
    assign div_acc_nx = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    assign div_lo_nx  = {lo_q[W-2:0], div_ge};
    assign quo_fin    = neg_q ? -div_lo_nx : div_lo_nx;
    assign rem_fin    = rneg_q ? -div_acc_nx : div_acc_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        stallreq = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !annul) begin
                    stallreq = 1'b1;
                    cnt_d    = CNT_W'(W);
                    acc_d    = '0;
                    if (is_div) begin
                        opnd_d = b_mag;
                        lo_d   = a_mag;
                        neg_d  = signed_op & (src_a[W-1] ^ src_b[W-1]);
                        rneg_d = signed_op & src_a[W-1];
                        if (src_b == '0) begin
                            state_d  = StDone;
                            res_hi_d = src_a;
                            res_lo_d = '1;
                            dbz_d    = 1'b1;
                        end else begin
                            state_d = StDiv;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d  = StDone;
                        res_hi_d = fast_prod[2*W-1:W];
                        res_lo_d = fast_prod[W-1:0];
                        dbz_d    = 1'b0;
`else
                        state_d = StMul;
                        opnd_d  = a_mag;
                        lo_d    = b_mag;
                        neg_d   = signed_op & (src_a[W-1] ^ src_b[W-1]);
                        rneg_d  = 1'b0;
`endif
                    end
                end
            end
            StMul: begin
                stallreq = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                state_d = StIdle;
`else
                if (annul) begin
                    state_d = StIdle;
                end else begin
                    acc_d = mul_acc_nx;
                    lo_d  = mul_lo_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = StDone;
                        res_hi_d = prod_fin[2*W-1:W];
                        res_lo_d = prod_fin[W-1:0];
                        dbz_d    = 1'b0;
                    end
                end
`endif
            end
            StDiv: begin
                stallreq = 1'b1;
                if (annul) begin
                    state_d = StIdle;
                end else begin
                    acc_d = div_acc_nx;
                    lo_d  = div_lo_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = StDone;
                        res_hi_d = rem_fin;
                        res_lo_d = quo_fin;
                        dbz_d    = 1'b0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Results are registered on the edge entering DONE so they are visible with valid.
    assign valid       = (state_q == StDone);
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized self-checking bench for ex_muldiv_unit (W=32).
//   Reference results come from 64-bit integer arithmetic. Honours
//   MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = W + 1;
`endif

    logic         clk = 1'b0;
    logic         resetn, start, annul;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         stallreq, valid, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .annul      (annul),
        .stallreq   (stallreq),
        .valid      (valid),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .div_by_zero(div_by_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dz, output int lat);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        lat = W + 1;
        case (o)
            2'b00: begin p = sa * sb; {hi, lo} = p; lat = MulLat; end
            2'b01: begin up = ua * ub; {hi, lo} = up; lat = MulLat; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    lo = 32'(q); hi = 32'(r);
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    lo = 32'(uq); hi = 32'(ur);
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          elat;
        int          got_lat;
        int          stall_bad;
        got_lat = -1;
        stall_bad = 0;
        ref_model(o, a, b, eh, el, ed, elat);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1 check_eq({tag, " stall_c0"}, 64'(stallreq), 64'd1);
        @(posedge clk);
        #1;
        // Operands change after the accepting edge and must be ignored.
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (valid) begin
                got_lat = c;
                break;
            end
            if (!stallreq) stall_bad++;
        end
        start = 1'b0;
        check_eq({tag, " latency"}, 64'(got_lat), 64'(elat));
        check_eq({tag, " hi"}, 64'(result_hi), 64'(eh));
        check_eq({tag, " lo"}, 64'(result_lo), 64'(el));
        check_eq({tag, " dbz"}, 64'(div_by_zero), 64'(ed));
        check_eq({tag, " stall_busy_drops"}, 64'(stall_bad), 64'd0);
        check_eq({tag, " stall_done"}, 64'(stallreq), 64'd0);
        @(negedge clk);
        check_eq({tag, " valid_pulse"}, 64'(valid), 64'd0);
    endtask

    initial begin
        logic [31:0] prev_hi, prev_lo;
        int          seen_valid;
        int          stall_high;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        resetn = 1'b0; start = 1'b0; annul = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        #1;
        check_eq("reset outputs", {valid, stallreq, div_by_zero, result_hi, result_lo}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0);
        run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0);
        run_op("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Annul of a divide at cycle 10.
        prev_hi = result_hi; prev_lo = result_lo;
        seen_valid = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        #1 check_eq("annul stall_c11", 64'(stallreq), 64'd0);
        stall_high = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen_valid++;
            if (stallreq) stall_high++;
        end
        check_eq("annul no_valid", 64'(seen_valid), 64'd0);
        check_eq("annul stays_idle", 64'(stall_high), 64'd0);
        check_eq("annul hold", {result_hi, result_lo}, {prev_hi, prev_lo});
        run_op("after_annul_9_3", 2'b11, 32'd9, 32'd3);

        // Annul in IDLE blocks acceptance.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        #1 check_eq("idle_annul stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1 check_eq("idle_annul not_accepted", 64'(stallreq), 64'd0);
        @(negedge clk);
        check_eq("idle_annul no_valid", 64'(valid), 64'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk);
        repeat (5) @(negedge clk);
        resetn = 1'b0; start = 1'b0;
        #1;
        check_eq("midreset outputs", {valid, stallreq, div_by_zero, result_hi, result_lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_reset_8_2", 2'b11, 32'd8, 32'd2);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 15);
                4: rb = -($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
